// File: rtl/drc_dvp_sampler.sv
// DVP input sampler: synchronises the camera pins, detects the selected
// PCLK edge, captures aligned pixels, flags frame/line events and
// watches for a stalled PCLK.
module drc_dvp_sampler #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PCLK_EDGE   = 1,
  parameter int unsigned VSYNC_POL   = 1,
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic [TIMEOUT_W-1:0] timeout_lmt_i,
  input  logic                 dvp_pclk_i,
  input  logic                 dvp_href_i,
  input  logic                 dvp_vsync_i,
  input  logic [DATA_W-1:0]    dvp_data_i,
  output logic                 pix_vld_o,
  output logic [DATA_W-1:0]    pix_data_o,
  output logic [CNT_W-1:0]     pix_cnt_o,
  output logic                 sof_o,
  output logic                 eol_o,
  output logic                 pclk_lost_o,
  output logic                 armed_o
);

  localparam int unsigned SYNC_W    = DATA_W + 3;
  localparam logic        EDGE_RISE = (PCLK_EDGE != 0);
  localparam logic        VPOL      = (VSYNC_POL != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2
  } state_e;

  logic [SYNC_W-1:0]    sync_q [SYNC_STAGES];
  logic                 pclk_s, href_s, vsync_s;
  logic [DATA_W-1:0]    data_s;
  logic                 pclk_d, href_q, vact_q;
  logic                 edge_c, vact_c;

  state_e               state_q, state_nx;
  logic [CNT_W-1:0]     idx_q, idx_nx, cnt_nx;
  logic [DATA_W-1:0]    data_nx;
  logic                 vld_nx, sof_nx, eol_nx;
  logic [TIMEOUT_W-1:0] wd_q, wd_nx;
  logic                 lost_nx;

  // Identical synchroniser chains keep data/HREF/VSYNC aligned to PCLK
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {dvp_pclk_i, dvp_href_i, dvp_vsync_i, dvp_data_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {pclk_s, href_s, vsync_s, data_s} = sync_q[SYNC_STAGES-1];

  assign edge_c = EDGE_RISE ? (pclk_s & ~pclk_d) : (~pclk_s & pclk_d);
  assign vact_c = ~(vsync_s ^ VPOL);

  // Previous PCLK level and the HREF/blanking state seen at the last edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pclk_d <= 1'b0;
      href_q <= 1'b0;
      vact_q <= 1'b0;
    end else begin
      pclk_d <= pclk_s;
      if (edge_c) begin
        href_q <= href_s;
        vact_q <= vact_c;
      end
    end
  end

  // Capture state machine: next state and next registered outputs
  always_comb begin
    state_nx = state_q;
    idx_nx   = idx_q;
    cnt_nx   = pix_cnt_o;
    data_nx  = pix_data_o;
    vld_nx   = 1'b0;
    sof_nx   = 1'b0;
    eol_nx   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i) state_nx = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (edge_c && vact_q && !vact_c) begin
          state_nx = ACTIVE;
          sof_nx   = 1'b1;
        end
      end
      ACTIVE: begin
        if (edge_c) begin
          if (href_s && !vact_c) begin
            vld_nx  = 1'b1;
            data_nx = data_s;
            cnt_nx  = idx_q;
            if (idx_q != CNT_MAX) idx_nx = idx_q + CNT_W'(1);
          end
          if (href_q && !href_s) begin
            eol_nx = 1'b1;
            cnt_nx = '0;
            idx_nx = '0;
          end
          if (!vact_q && vact_c) begin
            state_nx = WAIT_SOF;
            cnt_nx   = '0;
            idx_nx   = '0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!en_i) begin
      state_nx = IDLE;
      vld_nx   = 1'b0;
      sof_nx   = 1'b0;
      eol_nx   = 1'b0;
      cnt_nx   = '0;
      idx_nx   = '0;
    end
  end

  // State register and registered capture outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pix_cnt_o  <= '0;
      pix_data_o <= '0;
      pix_vld_o  <= 1'b0;
      sof_o      <= 1'b0;
      eol_o      <= 1'b0;
      armed_o    <= 1'b0;
    end else begin
      state_q    <= state_nx;
      idx_q      <= idx_nx;
      pix_cnt_o  <= cnt_nx;
      pix_data_o <= data_nx;
      pix_vld_o  <= vld_nx;
      sof_o      <= sof_nx;
      eol_o      <= eol_nx;
      armed_o    <= (state_nx == ACTIVE);
    end
  end

  // Watchdog: clear on every PCLK edge, otherwise count up to the limit
  always_comb begin
    if (edge_c)                     wd_nx = '0;
    else if (wd_q < timeout_lmt_i)  wd_nx = wd_q + TIMEOUT_W'(1);
    else                            wd_nx = timeout_lmt_i;
    lost_nx = (wd_nx == timeout_lmt_i) && (timeout_lmt_i != '0);
  end

  // Watchdog count and PCLK-lost flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_q        <= '0;
      pclk_lost_o <= 1'b0;
    end else begin
      wd_q        <= wd_nx;
      pclk_lost_o <= lost_nx;
    end
  end

endmodule

// File: tb/tb_drc_dvp_sampler.sv
// Directed bench for drc_dvp_sampler: a rising-edge/2-stage instance and a
// falling-edge/3-stage instance with a 2-bit pixel counter share the pins.
module tb_drc_dvp_sampler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en1, en2;
  logic [7:0] tmo1, tmo2;
  logic       pclk, href, vsync;
  logic [7:0] data;

  logic        vld1, sof1, eol1, lost1, armed1;
  logic [7:0]  data1;
  logic [11:0] cnt1;
  logic        vld2, sof2, eol2, lost2, armed2;
  logic [7:0]  data2;
  logic [1:0]  cnt2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_edge = 0;
  logic edge_lvl;
  int half;

  int q1_d[$], q1_c[$], q1_l[$];
  int q2_d[$], q2_c[$], q2_l[$];
  int sof1_n, eol1_n, sof1_lat, eol1_lat;
  int sof2_n, eol2_n, sof2_lat, eol2_lat;
  int lost_rise, lost_fall, lost1_hi, lost2_hi;
  logic lost1_p = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  drc_dvp_sampler #(.DATA_W(8), .SYNC_STAGES(2), .PCLK_EDGE(1), .VSYNC_POL(1),
                    .CNT_W(12), .TIMEOUT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .en_i(en1), .timeout_lmt_i(tmo1),
    .dvp_pclk_i(pclk), .dvp_href_i(href), .dvp_vsync_i(vsync), .dvp_data_i(data),
    .pix_vld_o(vld1), .pix_data_o(data1), .pix_cnt_o(cnt1), .sof_o(sof1),
    .eol_o(eol1), .pclk_lost_o(lost1), .armed_o(armed1));

  drc_dvp_sampler #(.DATA_W(8), .SYNC_STAGES(3), .PCLK_EDGE(0), .VSYNC_POL(1),
                    .CNT_W(2), .TIMEOUT_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .en_i(en2), .timeout_lmt_i(tmo2),
    .dvp_pclk_i(pclk), .dvp_href_i(href), .dvp_vsync_i(vsync), .dvp_data_i(data),
    .pix_vld_o(vld2), .pix_data_o(data2), .pix_cnt_o(cnt2), .sof_o(sof2),
    .eol_o(eol2), .pclk_lost_o(lost2), .armed_o(armed2));

  // Record pulses of both instances with their latency from the driven edge
  always @(negedge clk) begin
    if (vld1) begin
      q1_d.push_back(int'(data1)); q1_c.push_back(int'(cnt1)); q1_l.push_back(cyc - last_edge);
    end
    if (sof1) begin sof1_n++; sof1_lat = cyc - last_edge; end
    if (eol1) begin eol1_n++; eol1_lat = cyc - last_edge; end
    if (lost1 && !lost1_p) lost_rise = cyc;
    if (!lost1 && lost1_p) lost_fall = cyc;
    if (lost1) lost1_hi++;
    lost1_p = lost1;
    if (vld2) begin
      q2_d.push_back(int'(data2)); q2_c.push_back(int'(cnt2)); q2_l.push_back(cyc - last_edge);
    end
    if (sof2) begin sof2_n++; sof2_lat = cyc - last_edge; end
    if (eol2) begin eol2_n++; eol2_lat = cyc - last_edge; end
    if (lost2) lost2_hi++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PCLK period; pins change on the inactive edge
  task automatic pper(input logic h, input logic v, input logic [7:0] d);
    pclk = ~edge_lvl; href = h; vsync = v; data = d;
    clks(half);
    pclk = edge_lvl; last_edge = cyc;
    clks(half);
  endtask

  task automatic blank(input int n);
    repeat (n) pper(1'b0, 1'b1, 8'h00);
  endtask

  task automatic vs_low(input int n);
    repeat (n) pper(1'b0, 1'b0, 8'h00);
  endtask

  task automatic line(input int n, input int base);
    for (int i = 0; i < n; i++) pper(1'b1, 1'b0, 8'(base + i));
  endtask

  task automatic clear1();
    q1_d.delete(); q1_c.delete(); q1_l.delete();
    sof1_n = 0; eol1_n = 0; sof1_lat = -1; eol1_lat = -1;
  endtask

  initial begin
    pclk = 1'b0; href = 1'b0; vsync = 1'b0; data = 8'h00;
    en1 = 1'b0; en2 = 1'b0; tmo1 = 8'd20; tmo2 = 8'd0;
    edge_lvl = 1'b1; half = 2;
    lost_rise = -1; lost_fall = -1; lost1_hi = 0; lost2_hi = 0;
    sof2_n = 0; eol2_n = 0; sof2_lat = -1; eol2_lat = -1;
    clear1();

    // Reset values
    clks(3);
    @(negedge clk);
    check("rst_vld",   int'(vld1),   0);
    check("rst_data",  int'(data1),  0);
    check("rst_cnt",   int'(cnt1),   0);
    check("rst_sof",   int'(sof1),   0);
    check("rst_eol",   int'(eol1),   0);
    check("rst_lost",  int'(lost1),  0);
    check("rst_armed", int'(armed1), 0);
    check("rst_armed2", int'(armed2), 0);
    rst_n = 1'b1; en1 = 1'b1;
    clks(2);

    // Full frame: 3 lines x 5 pixels, data 0x10..0x1E
    clear1();
    blank(2); vs_low(2);
    for (int l = 0; l < 3; l++) begin
      line(5, 8'h10 + 5 * l);
      vs_low(2);
      if (l == 0) check("armed_mid_frame", int'(armed1), 1);
    end
    blank(2); clks(4);
    check("f_npix", q1_d.size(), 15);
    for (int i = 0; i < 15; i++) begin
      check($sformatf("f_data%0d", i), (i < q1_d.size()) ? q1_d[i] : -1, 8'h10 + i);
      check($sformatf("f_cnt%0d", i),  (i < q1_c.size()) ? q1_c[i] : -1, i % 5);
      check($sformatf("f_lat%0d", i),  (i < q1_l.size()) ? q1_l[i] : -1, 3);
    end
    check("f_sof_n", sof1_n, 1);
    check("f_sof_lat", sof1_lat, 3);
    check("f_eol_n", eol1_n, 3);
    check("f_eol_lat", eol1_lat, 3);
    check("f_armed_end", int'(armed1), 0);

    // Enable asserted mid-frame: capture starts only at the next frame
    en1 = 1'b0; clks(1); clear1();
    blank(2); vs_low(2); line(5, 8'h40); vs_low(1);
    en1 = 1'b1;
    line(5, 8'h50); vs_low(1);
    check("mf_no_pix", q1_d.size(), 0);
    blank(2); vs_low(2); line(5, 8'h60); vs_low(1); blank(2); clks(4);
    check("mf_npix", q1_d.size(), 5);
    check("mf_first_data", (q1_d.size() > 0) ? q1_d[0] : -1, 8'h60);
    check("mf_first_cnt", (q1_c.size() > 0) ? q1_c[0] : -1, 0);
    check("mf_sof_n", sof1_n, 1);

    // HREF falls on the same edge as frame end
    clear1();
    vs_low(1); line(3, 8'h30); blank(2); clks(4);
    check("hf_eol_n", eol1_n, 1);
    check("hf_npix", q1_d.size(), 3);
    check("hf_armed", int'(armed1), 0);
    vs_low(1); clks(4);
    check("hf_resof", sof1_n, 2);
    check("hf_rearmed", int'(armed1), 1);

    // Reset pulse mid-line
    line(2, 8'h70); clks(2);
    @(negedge clk);
    check("rl_pre_data", int'(data1), 8'h71);
    check("rl_pre_cnt", int'(cnt1), 1);
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rl_data", int'(data1), 0);
    check("rl_cnt", int'(cnt1), 0);
    check("rl_armed", int'(armed1), 0);
    check("rl_vld", int'(vld1), 0);
    check("rl_lost", int'(lost1), 0);
    rst_n = 1'b1;
    clks(1);

    // Enable dropped mid-line
    blank(2); vs_low(1); line(2, 8'h80); clks(2);
    @(negedge clk);
    check("ed_pre_data", int'(data1), 8'h81);
    check("ed_pre_armed", int'(armed1), 1);
    clks(1); en1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ed_armed", int'(armed1), 0);
    check("ed_cnt", int'(cnt1), 0);
    check("ed_data_kept", int'(data1), 8'h81);
    clks(1); clear1();
    line(3, 8'h88); vs_low(1); clks(4);
    check("ed_no_pix", q1_d.size(), 0);

    // Watchdog with limit 20: stop PCLK, then resume
    lost_rise = -1; lost_fall = -1;
    clks(36);
    check("wd_rise_delay", lost_rise - last_edge, 23);
    check("wd_lost_level", int'(lost1), 1);
    pper(1'b0, 1'b1, 8'h00); clks(4);
    check("wd_clear_delay", lost_fall - last_edge, 3);
    check("wd_cleared", int'(lost1), 0);

    // Watchdog disabled with limit 0
    tmo1 = 8'd0; lost1_hi = 0;
    clks(40);
    check("wd0_never", lost1_hi, 0);
    check("wd0_level", int'(lost1), 0);

    // Falling-edge instance, 3 sync stages, 2-bit saturating counter
    edge_lvl = 1'b0; half = 3; en2 = 1'b1; clks(1);
    clear1();
    q2_d.delete(); q2_c.delete(); q2_l.delete();
    sof2_n = 0; eol2_n = 0;
    blank(2); vs_low(1); line(5, 8'hA0); vs_low(1); blank(2); clks(6);
    check("fe_npix", q2_d.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fe_data%0d", i), (i < q2_d.size()) ? q2_d[i] : -1, 8'hA0 + i);
      check($sformatf("fe_cnt%0d", i),  (i < q2_c.size()) ? q2_c[i] : -1, (i < 3) ? i : 3);
      check($sformatf("fe_lat%0d", i),  (i < q2_l.size()) ? q2_l[i] : -1, 4);
    end
    check("fe_sof_n", sof2_n, 1);
    check("fe_sof_lat", sof2_lat, 4);
    check("fe_eol_n", eol2_n, 1);
    check("fe_eol_lat", eol2_lat, 4);
    check("fe_armed_end", int'(armed2), 0);
    check("fe_u1_idle", q1_d.size(), 0);
    check("u2_lost_never", lost2_hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
